phase_sequencer: RTL

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/legv8_ctrl_pkg.sv | 23 ++
 rtl/mem_wait_timer.sv | 36 +++
 rtl/phase_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/legv8_ctrl_pkg.sv
// Shared types and constants for the LEGv8 phase sequencer and its helpers.
package legv8_ctrl_pkg;

  localparam int          CNT_W               = 32;
  localparam logic [10:0] HALT_OPCODE_DEFAULT = 11'h6A2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALTED    = 3'd6,
    ST_ERROR     = 3'd7
  } state_e;

  // Active means an instruction is in flight (FETCH through WRITEBACK).
  function automatic logic is_active(state_e s);
    return (s >= ST_FETCH) && (s <= ST_WRITEBACK);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive MEMORY cycles spent waiting on mem_ready; expired_o flags
// the last allowed waiting cycle so the sequencer can leave for ERROR.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired_o = enable_i && (cnt_q == W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle LEGv8 phase sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// strobes, halt handling, memory timeout. Define PHASE_SEQ_PERF_COUNTERS_EN for counters.
module phase_sequencer
  import legv8_ctrl_pkg::*;
#(
  parameter int          MEM_TIMEOUT = 15,
  parameter logic [10:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic [10:0]      opcode,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             mem_ready,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             writeback_en,
  output logic             pc_en,
  output logic             mem_req,
  output logic             busy,
  output logic             halted,
  output logic             error,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  state_e state_q, state_d;
  logic   pending_q, pending_d;
  logic   mem_access;
  logic   tmr_expired;

  assign mem_access = mem_read | mem_write;

  // Strobes decode straight from the state register so reset drops them at once.
  assign fetch_en     = (state_q == ST_FETCH);
  assign decode_en    = (state_q == ST_DECODE);
  assign execute_en   = (state_q == ST_EXECUTE);
  assign writeback_en = (state_q == ST_WRITEBACK);
  assign pc_en        = (state_q == ST_WRITEBACK);
  assign mem_req      = (state_q == ST_MEMORY) && mem_access;
  assign busy         = is_active(state_q);
  assign halted       = (state_q == ST_HALTED);
  assign error        = (state_q == ST_ERROR);
  assign state        = state_q;

  mem_wait_timer #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_q != ST_MEMORY),
    .enable_i  (mem_req && !mem_ready),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (halt_req && busy) begin
      pending_d = 1'b1;
    end
    unique case (state_q)
      ST_IDLE, ST_HALTED: if (start) state_d = ST_FETCH;
      ST_FETCH:           state_d = ST_DECODE;
      ST_DECODE:          state_d = ST_EXECUTE;
      ST_EXECUTE:         state_d = ST_MEMORY;
      ST_MEMORY: begin
        if (!mem_access || mem_ready) begin
          state_d = ST_WRITEBACK;
        end else if (tmr_expired) begin
          state_d = ST_ERROR;
        end
      end
      // A halt request seen in this very cycle still stops at this boundary.
      ST_WRITEBACK: begin
        if ((opcode == HALT_OPCODE) || pending_q || halt_req) begin
          state_d   = ST_HALTED;
          pending_d = 1'b0;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_ERROR:           state_d = ST_ERROR;
      default:            state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

`ifdef PHASE_SEQ_PERF_COUNTERS_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  // Both counters stick at all-ones rather than wrapping.
  assign cycle_cnt_d = (busy && (cycle_cnt_q != '1)) ? cycle_cnt_q + CNT_W'(1) : cycle_cnt_q;
  assign instr_cnt_d = (writeback_en && (instr_cnt_q != '1)) ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_count = cycle_cnt_q;
  assign instr_count = instr_cnt_q;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule
